// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: captures each o_rx_dv byte into a
// DEPTH-entry FIFO and presents it on a first-word-fall-through read port.
// Reports the fill level, full and almost-full flags, and a sticky overrun
// flag that records bytes dropped while the FIFO was full.
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_rx_dv,
    input  logic [DATA_WIDTH-1:0]      i_rx_byte,
    output logic [DATA_WIDTH-1:0]      o_rd_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_overrun,
    input  logic                       i_clr_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_next;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Handshake decode and next fill level; a full FIFO still accepts a byte
    // when the head leaves on the same edge.
    always_comb begin
        pop        = o_rd_valid && i_rd_ready;
        push       = i_rx_dv && (!o_full || pop);
        drop       = i_rx_dv && o_full && !pop;
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Pointers, level and status flags; flags are registered from the next
    // level so they always agree with o_level.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            o_rd_valid    <= 1'b0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level         <= level_next;
            o_rd_valid    <= (level_next != '0);
            o_full        <= (level_next == LW'(DEPTH));
            o_almost_full <= (level_next >= LW'(AFULL_THRESH));
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_overrun <= 1'b0;
        end else if (drop) begin
            o_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            o_overrun <= 1'b0;
        end
    end

    // Storage write; contents need no reset since valid gates the output.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_rx_byte;
        end
    end

    // Head byte falls through combinationally; forced to zero while empty so
    // the port reads 0 out of reset regardless of storage contents.
    assign o_rd_data = o_rd_valid ? mem[rd_ptr] : '0;
    assign o_level   = level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic          clk;
    logic          rst_n;
    logic          rx_dv;
    logic [DW-1:0] rx_byte;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [4:0]    level;
    logic          full;
    logic          afull;
    logic          overrun;
    logic          clr;

    int            vectors;
    int            errors;
    logic [DW-1:0] q[$];
    logic          ovr_m;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .i_clk         (clk),
        .i_rstn        (rst_n),
        .i_rx_dv       (rx_dv),
        .i_rx_byte     (rx_byte),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .i_rd_ready    (rd_ready),
        .o_level       (level),
        .o_full        (full),
        .o_almost_full (afull),
        .o_overrun     (overrun),
        .i_clr_overrun (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one edge using the inputs currently
    // applied, then step the clock and settle just after the edge.
    task automatic cycle();
        bit pop_m;
        bit full_m;
        pop_m  = (q.size() > 0) && rd_ready;
        full_m = (q.size() == DEPTH);
        if (pop_m) void'(q.pop_front());
        if (rx_dv && (!full_m || pop_m)) q.push_back(rx_byte);
        if (rx_dv && full_m && !pop_m) ovr_m = 1'b1;
        else if (clr) ovr_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; rd_ready = 1'b0; clr = 1'b0;
        q.delete(); ovr_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || full !== 1'b0 || afull !== 1'b0 ||
            overrun !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: valid=%b level=%0d full=%b afull=%b ovr=%b data=%h, want all 0",
                     rd_valid, level, full, afull, overrun, rd_data);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        rx_dv = 1'b1; rx_byte = 8'hCE;
        cycle();
        rx_dv = 1'b0; rx_byte = 8'h77;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hCE || level !== 5'd1) begin
            errors++;
            $display("FAIL single_push: valid=%b data=%h level=%0d, want 1 ce 1", rd_valid, rd_data, level);
        end
        rd_ready = 1'b1;
        cycle();
        vectors++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: valid=%b level=%0d, want 0 0", rd_valid, level);
        end
        cycle();
        rd_ready = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL empty_pop: valid=%b level=%0d, want 0 0", rd_valid, level);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            rx_dv = 1'b1; rx_byte = DW'(i);
            cycle();
            vectors++;
            if (level !== 5'(i) || afull !== (i >= AFT) || full !== (i == DEPTH) || rd_data !== 8'h01) begin
                errors++;
                $display("FAIL fill[%0d]: level=%0d afull=%b full=%b head=%h, want %0d %b %b 01",
                         i, level, afull, full, rd_data, i, (i >= AFT), (i == DEPTH));
            end
        end
        rx_dv = 1'b0;
    endtask

    task automatic test_overrun();
        rx_dv = 1'b1; rx_byte = 8'hAA;
        cycle();
        rx_dv = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%b level=%0d full=%b, want 1 16 1", overrun, level, full);
        end
        rx_dv = 1'b1; clr = 1'b1;
        cycle();
        rx_dv = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins: ovr=%b, want 1", overrun);
        end
        cycle();
        clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || level !== 5'd16) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b level=%0d, want 0 16", overrun, level);
        end
    endtask

    task automatic test_full_push_pop();
        vectors++;
        if (rd_data !== 8'h01) begin
            errors++;
            $display("FAIL full_head: data=%h, want 01", rd_data);
        end
        rx_dv = 1'b1; rx_byte = 8'h55; rd_ready = 1'b1;
        cycle();
        rx_dv = 1'b0; rd_ready = 1'b0;
        vectors++;
        if (level !== 5'd16 || overrun !== 1'b0 || full !== 1'b1 || rd_data !== 8'h02) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovr=%b full=%b head=%h, want 16 0 1 02",
                     level, overrun, full, rd_data);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] last;
        last = '0;
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== q[0] || rd_data === 8'hAA) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b data=%h, want 1 %h", i, rd_valid, rd_data, q[0]);
            end
            last = rd_data;
            cycle();
        end
        rd_ready = 1'b0;
        vectors++;
        if (last !== 8'h55 || rd_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL drain_end: last=%h valid=%b level=%0d, want 55 0 0", last, rd_valid, level);
        end
    endtask

    task automatic test_random();
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || q.size() > 0) && cyc < 2000) begin
            rx_dv    = (sent < 40) && ($urandom_range(0, 2) != 0);
            rx_byte  = DW'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            if (rx_dv) sent++;
            cycle();
            cyc++;
            vectors++;
            if (level !== 5'(q.size()) || rd_valid !== (q.size() != 0) ||
                full !== (q.size() == DEPTH) || afull !== (q.size() >= AFT) ||
                overrun !== ovr_m || (q.size() != 0 && rd_data !== q[0])) begin
                errors++;
                $display("FAIL random[%0d]: level=%0d valid=%b data=%h ovr=%b, want %0d %b %h %b",
                         cyc, level, rd_valid, rd_data, overrun, q.size(), (q.size() != 0),
                         (q.size() != 0) ? q[0] : 8'h00, ovr_m);
            end
        end
        rx_dv = 1'b0; rd_ready = 1'b0;
        vectors++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL random_timeout: cycles=%0d, want < 2000", cyc);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            rx_dv = 1'b1; rx_byte = DW'($urandom);
            cycle();
        end
        rx_dv = 1'b0;
        vectors++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL pre_reset_level: level=%0d, want 5", level);
        end
        #3 rst_n = 1'b0;
        #1;
        q.delete(); ovr_m = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || overrun !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d ovr=%b data=%h, want 0 0 0 00",
                     rd_valid, level, overrun, rd_data);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rx_dv = 1'b1; rx_byte = 8'h3C;
        cycle();
        rx_dv = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C || level !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_push: valid=%b data=%h level=%0d, want 1 3c 1", rd_valid, rd_data, level);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_fill();
        test_overrun();
        test_full_push_pop();
        test_drain();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
